fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RISC datapath. It owns the program counter, drives the instruction-memory address, and captures the returned word together with its PC into a small prefetch buffer. Instructions leave through a valid/ready handshake to decode and register-file read. A redirect port, driven by branch/jump resolution, flushes the buffer and restarts fetch at a new target.

---
 rtl/processor_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// +----------------------------------------------------------------------+
// | processor_pkg                                                         |
// | Shared fetch-stage constants: FSM states, PC increment, widths.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package processor_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int PC_INC         = 4;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +----------------------------------------------------------------------+
// | fetch_fifo                                                            |
// | Synchronous DEPTH-entry prefetch FIFO of {pc, instr} with clear.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import processor_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_clear,
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  input  logic [DATA_WIDTH-1:0]   i_instr,
  output logic [ADDR_WIDTH-1:0]   o_head_pc,
  output logic [DATA_WIDTH-1:0]   o_head_instr,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_instr [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  // Storage is reset too, so the head reads {RESET_PC, 0} straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= RESET_PC;
        r_instr[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_pc[r_wr_ptr]    <= i_pc;
        r_instr[r_wr_ptr] <= i_instr;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head_pc    = r_pc[r_rd_ptr];
  assign o_head_instr = r_instr[r_rd_ptr];
  assign o_count      = r_count;
  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | fetch_unit                                                            |
// | Instruction fetch: PC, FSM, redirect, prefetch buffer handshake.      |
// | Optional perf counters enabled by `define FETCH_PERF_CNT_EN.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import processor_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rd,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc_4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int                    CW       = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] C_PC_INC = ADDR_WIDTH'(PC_INC);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic                  w_unused_rpc_lo;

  assign w_unused_rpc_lo = ^redirect_pc[1:0];

  assign w_pop  = out_valid & out_ready;
  assign w_push = (r_state != S_RESET) && !redirect_valid && (!w_full || w_pop);

  // FULL means "holding DEPTH entries with nothing leaving", whichever way we got there.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_RESET: w_state_next = S_RUN;
        S_RUN: begin
          if (!w_pop && (w_full || (w_push && w_count == CW'(DEPTH - 1)))) begin
            w_state_next = S_FULL;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_next = S_RUN;
          end
        end
        default: w_state_next = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_push) begin
        r_pc <= r_pc + C_PC_INC;
      end
    end
  end

  fetch_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_clear      (redirect_valid),
    .i_pc         (r_pc),
    .i_instr      (imem_rd),
    .o_head_pc    (w_head_pc),
    .o_head_instr (out_instr),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_head_pc;
  assign out_pc_4  = w_head_pc + C_PC_INC;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end
      if (r_state == S_FULL) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_fetch_unit                                                         |
// | Randomized + directed self-checking bench for fetch_unit.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  assign imem_rd = 32'h0000_0013 + {16'h0, imem_addr};

  fetch_unit #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .RESET_PC   (16'h0000),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_4       (out_pc_4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the buffer is a queue of PCs; instructions follow from the imem rule.
  bit          m_known   = 0;
  bit          m_started = 0;
  bit          m_full    = 0;
  logic [15:0] m_pc      = '0;
  logic [15:0] m_q[$];
  logic [31:0] m_fetch   = '0;
  logic [31:0] m_stall   = '0;

  logic [15:0] dlv[$];
  logic [15:0] dlv4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
    chk("out_valid", {31'h0, out_valid}, {31'h0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      chk("out_pc", {16'h0, out_pc}, {16'h0, m_q[0]});
      chk("out_pc_4", {16'h0, out_pc_4}, {16'h0, 16'(m_q[0] + 16'd4)});
      chk("out_instr", out_instr, 32'h13 + {16'h0, m_q[0]});
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [15:0] rp, input bit rd);
    bit pop;
    bit push;
    pop = (m_q.size() > 0) && rd;
    if (r) begin
      m_q.delete();
      m_pc      = 16'h0000;
      m_started = 0;
      m_full    = 0;
      m_fetch   = '0;
      m_stall   = '0;
      m_known   = 1;
    end else begin
      if (m_full) m_stall++;
      if (rv) begin
        m_q.delete();
        m_pc      = {rp[15:2], 2'b00};
        m_full    = 0;
        m_started = 1;
      end else begin
        push = m_started && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 16'd4;
          m_fetch++;
        end
        m_full    = !pop && (m_q.size() == DEPTH);
        m_started = 1;
      end
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle(input bit r, input bit rv, input logic [15:0] rp, input bit rd);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rd;
    @(negedge clk);
    if (m_known) compare();
    if (out_valid && rd) begin
      dlv.push_back(out_pc);
      dlv4.push_back(out_pc_4);
    end
    model_step(r, rv, rp, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          base;
    logic [15:0] h;

    cycle(1, 0, 16'h0, 1);
    cycle(1, 0, 16'h0, 1);
    chk("rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst imem_addr", {16'h0, imem_addr}, 32'h0000);
    chk("rst out_pc", {16'h0, out_pc}, 32'h0000);
    chk("rst out_pc_4", {16'h0, out_pc_4}, 32'h0004);
    chk("rst out_instr", out_instr, 32'h0);

    cycle(0, 0, 16'h0, 1);
    chk("cyc1 out_valid", {31'h0, out_valid}, 32'h0);
    cycle(0, 0, 16'h0, 1);
    chk("cyc2 out_valid", {31'h0, out_valid}, 32'h1);
    chk("cyc2 out_pc", {16'h0, out_pc}, 32'h0000);
    chk("cyc2 out_pc_4", {16'h0, out_pc_4}, 32'h0004);

    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 0);
    chk("stall imem_addr", {16'h0, imem_addr}, 32'h0008);
`ifdef FETCH_PERF_CNT_EN
    chk("stall perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif
    base = dlv.size();
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 1);
    chk("release first", (dlv.size() > base) ? {16'h0, dlv[base]} : 32'hdead, 32'h0000);
    chk("release second", (dlv.size() > base + 1) ? {16'h0, dlv[base+1]} : 32'hdead, 32'h0004);

    cycle(0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 0);
    cycle(0, 1, 16'h0123, 0);
    chk("redir full imem_addr", {16'h0, imem_addr}, 32'h0120);
    chk("redir full out_valid", {31'h0, out_valid}, 32'h0);
    base = dlv.size();
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 1);
    chk("redir full next pc", (dlv.size() > base) ? {16'h0, dlv[base]} : 32'hdead, 32'h0120);

    chk("hs redirect valid", {31'h0, out_valid}, 32'h1);
    h    = out_pc;
    base = dlv.size();
    cycle(0, 1, 16'h0200, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 1);
    chk("hs redirect head", (dlv.size() > base) ? {16'h0, dlv[base]} : 32'hdead, {16'h0, h});
    chk("hs redirect next", (dlv.size() > base + 1) ? {16'h0, dlv[base+1]} : 32'hdead, 32'h0200);

    base = dlv.size();
    cycle(0, 1, 16'hFFF8, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 1);
    chk("wrap pc0", (dlv.size() > base) ? {16'h0, dlv[base]} : 32'hdead, 32'hFFF8);
    chk("wrap pc1", (dlv.size() > base + 1) ? {16'h0, dlv[base+1]} : 32'hdead, 32'hFFFC);
    chk("wrap pc2", (dlv.size() > base + 2) ? {16'h0, dlv[base+2]} : 32'hdead, 32'h0000);
    chk("wrap pc_4", (dlv4.size() > base + 1) ? {16'h0, dlv4[base+1]} : 32'hdead, 32'h0000);

    cycle(0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst imem_addr", {16'h0, imem_addr}, 32'h0000);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 1);
    chk("midrst restart valid", {31'h0, out_valid}, 32'h1);
    chk("midrst restart pc", {16'h0, out_pc}, 32'h0000);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 5),
            16'($urandom), ($urandom_range(0, 99) < 70));
    end
    cycle(0, 0, 16'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
